// File: rtl/mmcm_reset_sequencer_if.sv
// Status and control bundle between the MMCM reset sequencer and the board/MMCM side.
// The master modport is the sequencer; the slave modport is the MMCM/board side.
interface mmcm_reset_sequencer_if #(
  parameter int unsigned RETRY_W = 3
);
  logic               locked_async;
  logic               soft_reset;
  logic               mmcm_rst;
  logic               core_reset_n;
  logic               ready;
  logic               lock_fail;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  locked_async, soft_reset,
    output mmcm_rst, core_reset_n, ready, lock_fail, retry_count
  );

  modport slave (
    output locked_async, soft_reset,
    input  mmcm_rst, core_reset_n, ready, lock_fail, retry_count
  );
endinterface

// File: rtl/mmcm_reset_sequencer.sv
// Drives the MMCM reset, waits for a settled lock with bounded retries and releases core reset.
// Runs on the MMCM reference clock so it keeps ticking while the MMCM is held in reset.
module mmcm_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned RETRY_W             = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mmcm_reset_sequencer_if.master bus
);

  localparam int unsigned MaxAB  = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ?
                                   LOCK_TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int unsigned MaxCnt = (MaxAB > RST_PULSE_CYCLES) ? MaxAB : RST_PULSE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StRstMmcm,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RETRY_W-1:0]     retry_q, retry_d, retry_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   mmcm_rst_q, core_reset_n_q, ready_q, lock_fail_q;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    retry_d = retry_q;
    if (bus.soft_reset) begin
      state_d = StRstMmcm;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StRstMmcm: begin
          if (cnt_q == CntW'(RST_PULSE_CYCLES - 1)) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          // Lock wins over a timeout landing on the same cycle.
          if (locked_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? StFail : StRstMmcm;
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (!locked_s) state_d = StRstMmcm;
        end
        StFail: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StRstMmcm;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRstMmcm;
      cnt_q          <= '0;
      retry_q        <= '0;
      sync_q         <= '0;
      mmcm_rst_q     <= 1'b1;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_fail_q    <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.locked_async};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      mmcm_rst_q     <= (state_d == StRstMmcm) || (state_d == StFail);
      core_reset_n_q <= (state_d == StRun);
      ready_q        <= (state_d == StRun);
      lock_fail_q    <= (state_d == StFail);
    end
  end

  assign bus.mmcm_rst     = mmcm_rst_q;
  assign bus.core_reset_n = core_reset_n_q;
  assign bus.ready        = ready_q;
  assign bus.lock_fail    = lock_fail_q;
  assign bus.retry_count  = retry_q;

endmodule

// File: doc/mmcm_reset_sequencer.md
Name: mmcm_reset_sequencer

Overview:
- Consumes the LOCKED status of the board MMCM clock generator and drives that generator's reset input.
- Produces a clean core reset that stays asserted until the MMCM has held lock for a programmable settle time.
- Retries lock acquisition with bounded timeouts and flags a hard failure once retries are exhausted.
- Clocked from the free-running MMCM input reference clock, not an MMCM output, so it keeps running while the MMCM is held in reset. Generated-clock domains bridge CORE_RESET_N locally.

Parameters:
RST_PULSE_CYCLES, 16, cycles MMCM_RST is held high per reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 100000, max cycles in WAIT_LOCK before a retry (1 ms at 100 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1)
MAX_RETRIES, 4, lock timeouts tolerated in one acquisition before FAIL (>=1)
SYNC_STAGES, 2, flop stages on LOCKED_ASYNC (>=2)
RETRY_W, 3, width of RETRY_COUNT; must hold MAX_RETRIES

Ports:
CLK  in  1  free-running reference clock (MMCM input clock)
ASYNC_RESET_N  in  1  asynchronous active-low reset, deassertion assumed synchronous to CLK by board logic
LOCKED_ASYNC  in  1  MMCM LOCKED, asynchronous to CLK
SOFT_RESET  in  1  synchronous one-cycle request to restart the full sequence
MMCM_RST  out  1  active-high reset to the MMCM
CORE_RESET_N  out  1  active-low core reset, CLK domain
READY  out  1  high only in RUN
LOCK_FAIL  out  1  sticky; retries exhausted
RETRY_COUNT  out  RETRY_W  lock timeouts in the current acquisition

Behaviour:
- Reset values: MMCM_RST=1, CORE_RESET_N=0, READY=0, LOCK_FAIL=0, RETRY_COUNT=0.
- Reset state: state=RST_MMCM, cycle counter=0, all sync flops=0.
- Outputs are registered and Moore-decoded from the next state. Each output changes on the same edge as the state transition.
- locked_s is the last stage of the SYNC_STAGES synchronizer.
- One shared cycle counter, width $clog2(max(LOCK_TIMEOUT_CYCLES, STABLE_CYCLES, RST_PULSE_CYCLES)+1). It is cleared on every state entry.
- RST_MMCM:
  - MMCM_RST=1, CORE_RESET_N=0, READY=0.
  - Stays exactly RST_PULSE_CYCLES cycles, then moves to WAIT_LOCK.
- WAIT_LOCK:
  - MMCM_RST=0, CORE_RESET_N=0.
  - locked_s=1 -> STABLE.
  - Otherwise, on the LOCK_TIMEOUT_CYCLES-th cycle: RETRY_COUNT+1.
    - If the new value equals MAX_RETRIES -> FAIL.
    - Else -> RST_MMCM.
  - If locked_s rises on the timeout cycle, lock wins and the state goes to STABLE.
- STABLE:
  - The counter advances on each cycle with locked_s=1.
  - locked_s=0 on any cycle -> WAIT_LOCK with a fresh timeout window. RETRY_COUNT is unchanged.
  - After STABLE_CYCLES consecutive locked cycles -> RUN.
- RUN:
  - CORE_RESET_N=1, READY=1, MMCM_RST=0.
  - RETRY_COUNT is cleared on entry.
  - locked_s=0 -> RST_MMCM. CORE_RESET_N=0 and READY=0 on that same edge (lock-loss latency = SYNC_STAGES+1 edges from LOCKED_ASYNC falling).
- FAIL:
  - MMCM_RST=1, CORE_RESET_N=0, LOCK_FAIL=1, RETRY_COUNT=MAX_RETRIES.
  - Held until SOFT_RESET or ASYNC_RESET_N.
- SOFT_RESET=1, any state:
  - Next state RST_MMCM, counter=0, RETRY_COUNT=0, LOCK_FAIL=0, CORE_RESET_N=0.
  - Overrides every other transition in the same cycle.
  - SOFT_RESET held high keeps the block in RST_MMCM with the counter at 0.
- Async reset mid-operation: all outputs go immediately to their reset values without waiting for a clock edge.
- CORE_RESET_N must never glitch high. A lock bounce shorter than STABLE_CYCLES never reaches RUN.

Test Plan:
- Bench parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- LOCKED_ASYNC tied high, release reset -> MMCM_RST high for edges 1-4, falls on edge 4. CORE_RESET_N and READY rise on edge 13. RETRY_COUNT=0.
- LOCKED_ASYNC low throughout -> two windows of 4 reset + 50 wait cycles. RETRY_COUNT goes 1 then 2. LOCK_FAIL=1 and MMCM_RST=1 from edge 108, stable for 200 further cycles.
- LOCKED high 5 cycles, low 1, then high, during STABLE -> return to WAIT_LOCK then STABLE. CORE_RESET_N rises only after 8 unbroken locked cycles. RETRY_COUNT stays 0.
- In RUN, drop LOCKED_ASYNC -> CORE_RESET_N=0 and READY=0 exactly 3 edges later, MMCM_RST=1 for 4 cycles. Restore lock -> RUN again.
- From FAIL, pulse SOFT_RESET one cycle with LOCKED high -> LOCK_FAIL and RETRY_COUNT clear next edge. Sequence restarts and RUN is reached. Assert ASYNC_RESET_N low mid-STABLE -> outputs at reset values asynchronously.
